// File: rtl/fetch_pc_unit_pkg.sv
// Shared fetch-stage constants for the 5-stage MIPS pipeline.
//   RESET_VEC / EXC_VEC : reset and exception entry addresses
//   IMEM_LO / IMEM_HI   : legal fetch window (inclusive)
//   PC_STEP             : sequential fetch increment in bytes
//   pc_sel_e            : next-PC source, in priority order
package fetch_pc_unit_pkg;

  localparam logic [31:0] MIPS_RESET_VEC = 32'h0000_3000;
  localparam logic [31:0] MIPS_EXC_VEC   = 32'h0000_4180;
  localparam logic [31:0] MIPS_IMEM_LO   = 32'h0000_3000;
  localparam logic [31:0] MIPS_IMEM_HI   = 32'h0000_6FFC;
  localparam logic [31:0] MIPS_PC_STEP   = 32'd4;

  typedef enum logic [2:0] {
    SEL_EXC,     // exception vector
    SEL_ERET,    // return to EPC
    SEL_REDIR,   // live branch/jump redirect
    SEL_PEND,    // buffered redirect released
    SEL_SEQ,     // pc + PC_STEP
    SEL_BUFFER,  // stalled redirect captured, pc holds
    SEL_HOLD     // stalled, nothing changes
  } pc_sel_e;

endpackage

// File: rtl/fetch_pc_unit.sv
// Fetch-stage program counter.
// Selects the next fetch address from exception vector, ERET return, branch
// redirect, a redirect buffered during a stall, or sequential +PC_STEP.
// Ports:
//   clk, reset      rising-edge clock, synchronous active-high reset
//   pc_en           advance PC (0 = stall from hazard unit)
//   redir_valid     branch/jump taken, redir_target valid
//   redir_target    redirect target
//   exc_req         exception taken, overrides stall
//   eret_req        ERET executed, overrides stall
//   epc_i           ERET return address
//   pc_o            current fetch PC (registered)
//   adel_o          fetch address error for pc_o (combinational from pc_o)
//   redir_pend_o    a buffered redirect is waiting (registered)
//   fetch_cnt_o     number of PC updates since reset (registered, wraps)
module fetch_pc_unit
  import fetch_pc_unit_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC = MIPS_RESET_VEC[ADDR_W-1:0],
  parameter logic [ADDR_W-1:0] EXC_VEC   = MIPS_EXC_VEC[ADDR_W-1:0],
  parameter logic [ADDR_W-1:0] PC_STEP   = MIPS_PC_STEP[ADDR_W-1:0],
  parameter logic [ADDR_W-1:0] IMEM_LO   = MIPS_IMEM_LO[ADDR_W-1:0],
  parameter logic [ADDR_W-1:0] IMEM_HI   = MIPS_IMEM_HI[ADDR_W-1:0],
  parameter int unsigned       CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pc_en,
  input  logic              redir_valid,
  input  logic [ADDR_W-1:0] redir_target,
  input  logic              exc_req,
  input  logic              eret_req,
  input  logic [ADDR_W-1:0] epc_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic              adel_o,
  output logic              redir_pend_o,
  output logic [CNT_W-1:0]  fetch_cnt_o
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              pend_q, pend_d;
  logic [ADDR_W-1:0] pend_tgt_q, pend_tgt_d;
  logic [CNT_W-1:0]  cnt_q;
  logic              pc_update;
  pc_sel_e           sel;

  // Priority select: exc > eret > live redirect > buffered redirect > +STEP.
  always_comb begin
    if (exc_req)                    sel = SEL_EXC;
    else if (eret_req)              sel = SEL_ERET;
    else if (pc_en && redir_valid)  sel = SEL_REDIR;
    else if (pc_en && pend_q)       sel = SEL_PEND;
    else if (pc_en)                 sel = SEL_SEQ;
    else if (redir_valid)           sel = SEL_BUFFER;
    else                            sel = SEL_HOLD;
  end

  always_comb begin
    pc_d       = pc_q;
    pend_d     = pend_q;
    pend_tgt_d = pend_tgt_q;
    pc_update  = 1'b0;
    unique case (sel)
      SEL_EXC: begin
        pc_d      = EXC_VEC;
        pend_d    = 1'b0;
        pc_update = 1'b1;
      end
      SEL_ERET: begin
        pc_d      = epc_i;
        pend_d    = 1'b0;
        pc_update = 1'b1;
      end
      SEL_REDIR: begin
        pc_d      = redir_target;
        pend_d    = 1'b0;
        pc_update = 1'b1;
      end
      SEL_PEND: begin
        pc_d      = pend_tgt_q;
        pend_d    = 1'b0;
        pc_update = 1'b1;
      end
      SEL_SEQ: begin
        pc_d      = pc_q + PC_STEP;
        pc_update = 1'b1;
      end
      SEL_BUFFER: begin
        // Latest redirect seen during a stall wins.
        pend_d     = 1'b1;
        pend_tgt_d = redir_target;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= RESET_VEC;
      pend_q     <= 1'b0;
      pend_tgt_q <= '0;
      cnt_q      <= '0;
    end else begin
      pc_q       <= pc_d;
      pend_q     <= pend_d;
      pend_tgt_q <= pend_tgt_d;
      if (pc_update) cnt_q <= cnt_q + 1'b1;
    end
  end

  assign pc_o         = pc_q;
  assign redir_pend_o = pend_q;
  assign fetch_cnt_o  = cnt_q;
  assign adel_o       = (pc_q[1:0] != 2'b00) || (pc_q < IMEM_LO) || (pc_q > IMEM_HI);

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit: directed scenarios followed by
// randomized traffic, compared every cycle against a behavioural model.
module tb_fetch_pc_unit;

  logic        clk;
  logic        reset;
  logic        pc_en;
  logic        redir_valid;
  logic [31:0] redir_target;
  logic        exc_req;
  logic        eret_req;
  logic [31:0] epc_i;
  logic [31:0] pc_o;
  logic        adel_o;
  logic        redir_pend_o;
  logic [15:0] fetch_cnt_o;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Reference model state
  logic [31:0] m_pc;
  logic        m_pend;
  logic [31:0] m_tgt;
  int unsigned m_cnt;

  fetch_pc_unit #(
    .ADDR_W (32),
    .CNT_W  (16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .pc_en        (pc_en),
    .redir_valid  (redir_valid),
    .redir_target (redir_target),
    .exc_req      (exc_req),
    .eret_req     (eret_req),
    .epc_i        (epc_i),
    .pc_o         (pc_o),
    .adel_o       (adel_o),
    .redir_pend_o (redir_pend_o),
    .fetch_cnt_o  (fetch_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic bad_addr(input logic [31:0] a);
    return (a % 4 != 0) || (a < 32'h3000) || (a > 32'h6FFC);
  endfunction

  // One clock: model predicts from the inputs as set, then all outputs compared.
  task automatic step();
    logic [31:0] npc;
    logic        npend;
    logic [31:0] ntgt;
    int unsigned ncnt;
    npc = m_pc; npend = m_pend; ntgt = m_tgt; ncnt = m_cnt;
    if (reset) begin
      npc = 32'h3000; npend = 0; ntgt = 0; ncnt = 0;
    end else begin
      if (exc_req)                   begin npc = 32'h4180;     npend = 0; end
      else if (eret_req)             begin npc = epc_i;        npend = 0; end
      else if (pc_en && redir_valid) begin npc = redir_target; npend = 0; end
      else if (pc_en && m_pend)      begin npc = m_tgt;        npend = 0; end
      else if (pc_en)                      npc = m_pc + 32'd4;
      else if (redir_valid)          begin npend = 1; ntgt = redir_target; end
      if (exc_req || eret_req || pc_en) ncnt = (m_cnt + 1) % 65536;
    end
    @(posedge clk);
    #1;
    m_pc = npc; m_pend = npend; m_tgt = ntgt; m_cnt = ncnt;
    check("pc", pc_o, m_pc);
    check("pend", {31'd0, redir_pend_o}, {31'd0, m_pend});
    check("cnt", {16'd0, fetch_cnt_o}, m_cnt);
    check("adel", {31'd0, adel_o}, {31'd0, bad_addr(m_pc)});
  endtask

  task automatic idle_inputs();
    reset = 0; pc_en = 0; redir_valid = 0; redir_target = 0;
    exc_req = 0; eret_req = 0; epc_i = 0;
  endtask

  function automatic logic [31:0] rand_target();
    case ($urandom_range(0, 5))
      0:       return 32'h3000 + ($urandom_range(0, 16'h0FFF) << 2);
      1:       return $urandom();
      2:       return 32'h2FFC;
      3:       return 32'h7000;
      4:       return 32'h6FFC;
      default: return 32'h3000 + $urandom_range(0, 16'h3FFF);
    endcase
  endfunction

  initial begin
    m_pc = 0; m_pend = 0; m_tgt = 0; m_cnt = 0;
    idle_inputs();
    reset = 1;
    step();
    step();
    reset = 0;
    check("reset_pc", pc_o, 32'h3000);
    check("reset_cnt", {16'd0, fetch_cnt_o}, 32'd0);

    // Sequential fetch
    pc_en = 1;
    repeat (3) step();
    check("seq_pc", pc_o, 32'h300C);
    check("seq_cnt", {16'd0, fetch_cnt_o}, 32'd3);

    // Redirect during stall is buffered and released with no extra latency
    pc_en = 0; redir_valid = 1; redir_target = 32'h3100;
    step();
    redir_valid = 0;
    repeat (2) step();
    check("stall_hold_pc", pc_o, 32'h300C);
    check("stall_pend", {31'd0, redir_pend_o}, 32'd1);
    pc_en = 1;
    step();
    check("release_pc", pc_o, 32'h3100);
    check("release_pend", {31'd0, redir_pend_o}, 32'd0);

    // Latest buffered redirect wins
    pc_en = 0; redir_valid = 1; redir_target = 32'h3100;
    step();
    redir_target = 32'h3200;
    step();
    redir_valid = 0; pc_en = 1;
    step();
    check("latest_wins", pc_o, 32'h3200);

    // Exception discards pending redirect, then ERET
    pc_en = 0; redir_valid = 1; redir_target = 32'h3300;
    step();
    redir_valid = 0; exc_req = 1;
    step();
    exc_req = 0;
    check("exc_pc", pc_o, 32'h4180);
    check("exc_pend", {31'd0, redir_pend_o}, 32'd0);
    eret_req = 1; epc_i = 32'h3010;
    step();
    eret_req = 0;
    check("eret_pc", pc_o, 32'h3010);

    // exc and eret together
    exc_req = 1; eret_req = 1;
    step();
    exc_req = 0; eret_req = 0;
    check("exc_over_eret", pc_o, 32'h4180);

    // Address error boundaries
    pc_en = 1; redir_valid = 1;
    redir_target = 32'h3002; step();
    check("adel_misalign", {31'd0, adel_o}, 32'd1);
    redir_target = 32'h2FFC; step();
    check("adel_low", {31'd0, adel_o}, 32'd1);
    redir_target = 32'h7000; step();
    check("adel_high", {31'd0, adel_o}, 32'd1);
    redir_target = 32'h6FFC; step();
    check("adel_top_ok", {31'd0, adel_o}, 32'd0);
    redir_valid = 0;

    // PC wraps silently
    pc_en = 0; eret_req = 1; epc_i = 32'hFFFF_FFFC;
    step();
    eret_req = 0; pc_en = 1;
    step();
    check("pc_wrap", pc_o, 32'h0000_0000);

    // Reset mid-stall with a pending redirect
    pc_en = 0; redir_valid = 1; redir_target = 32'h3400;
    step();
    reset = 1;
    step();
    idle_inputs();
    check("rst_stall_pc", pc_o, 32'h3000);
    check("rst_stall_pend", {31'd0, redir_pend_o}, 32'd0);
    check("rst_stall_cnt", {16'd0, fetch_cnt_o}, 32'd0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      reset        = ($urandom_range(0, 59) == 0);
      pc_en        = ($urandom_range(0, 2) != 0);
      redir_valid  = ($urandom_range(0, 2) == 0);
      redir_target = rand_target();
      exc_req      = ($urandom_range(0, 19) == 0);
      eret_req     = ($urandom_range(0, 19) == 0);
      epc_i        = rand_target();
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
